// File: rtl/cpu_pkg.sv
// Shared CPU word/opcode sizing and the memory-mapped I/O addresses at the top
// of the data address space.
package cpu_pkg;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned SW_ADDR   = 2**(WORD_W - OP_W) - 1;
    localparam int unsigned DISP_ADDR = 2**(WORD_W - OP_W) - 2;

endpackage

// File: rtl/switch_input_sync2.sv
// Two-flop synchroniser for a vector of asynchronous levels.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/switch_input.sv
// Slide-switch conditioner: synchronise, debounce the whole word, hold a stable
// copy on Sdata and flag new/overrun data for the CPU read path.
module switch_input #(
    parameter int unsigned WORD_W    = cpu_pkg::WORD_W,
    parameter int unsigned OP_W      = cpu_pkg::OP_W,
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic [WORD_W-1:0] switches,
    input  logic              rd,
    output logic [WORD_W-1:0] Sdata,
    output logic              new_data,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || WORD_W <= OP_W) begin : g_param_check
        $error("switch_input: DB_CYCLES must be >= 2 and WORD_W must exceed OP_W");
    end

    logic [WORD_W-1:0] s2;
    logic [WORD_W-1:0] cand;
    logic [CNT_W-1:0]  cnt;
    logic              accept;

    sync2 #(.W(WORD_W)) u_sync (
        .clock   (clock),
        .n_reset (n_reset),
        .d       (switches),
        .q       (s2)
    );

    // Accept only once the count has saturated on an unchanged candidate that
    // differs from what is already published.
    always_comb begin
        accept = (s2 == cand) && (cnt == CNT_MAX) && (cand != Sdata);
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            cand  <= '0;
            cnt   <= '0;
            Sdata <= '0;
        end else begin
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                Sdata <= cand;
            end
        end
    end

    // A same-cycle accept beats the read so fresh data is never lost.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            new_data <= 1'b0;
            overrun  <= 1'b0;
        end else if (accept) begin
            new_data <= 1'b1;
            if (new_data) begin
                overrun <= 1'b1;
            end
        end else if (rd) begin
            new_data <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_switch_input.sv
// Directed bench for switch_input with a sample-window reference model.
module tb_switch_input;

    localparam int DB = 4;

    logic       clock;
    logic       n_reset;
    logic [7:0] switches;
    logic       rd;
    logic [7:0] Sdata;
    logic       new_data;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    // Model state: the input samples taken at recent edges and the expected outputs.
    logic [7:0] past [0:DB+2];
    logic [7:0] m_sdata;
    logic       m_new;
    logic       m_ov;

    switch_input #(
        .WORD_W    (8),
        .OP_W      (3),
        .DB_CYCLES (DB)
    ) dut (
        .clock    (clock),
        .n_reset  (n_reset),
        .switches (switches),
        .rd       (rd),
        .Sdata    (Sdata),
        .new_data (new_data),
        .overrun  (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // A value is published at edge e when the samples taken at edges e-2-DB .. e-2
    // (two sync stages, then DB+1 equal observations) all agree and differ from Sdata.
    initial begin
        forever begin
            @(posedge clock or negedge n_reset);
            if (!n_reset) begin
                for (int j = 0; j <= DB + 2; j++) past[j] = 8'h00;
                m_sdata = 8'h00;
                m_new   = 1'b0;
                m_ov    = 1'b0;
            end else begin
                bit stable;
                for (int j = DB + 2; j > 0; j--) past[j] = past[j-1];
                past[0] = switches;
                stable = 1'b1;
                for (int j = 3; j <= DB + 2; j++) begin
                    if (past[j] != past[2]) stable = 1'b0;
                end
                if (stable && past[2] != m_sdata) begin
                    m_ov    = m_ov | m_new;
                    m_new   = 1'b1;
                    m_sdata = past[2];
                end else if (rd) begin
                    m_new = 1'b0;
                    m_ov  = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            check("model_sdata",    {24'h0, Sdata},    {24'h0, m_sdata});
            check("model_new_data", {31'h0, new_data}, {31'h0, m_new});
            check("model_overrun",  {31'h0, overrun},  {31'h0, m_ov});
        end
    end

    task automatic expect_out(input string name, input logic [7:0] sd, input logic nd, input logic ov);
        check({name, "_sdata"},    {24'h0, Sdata},    {24'h0, sd});
        check({name, "_new_data"}, {31'h0, new_data}, {31'h0, nd});
        check({name, "_overrun"},  {31'h0, overrun},  {31'h0, ov});
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clock);
        rd = 1'b0;
    endtask

    initial begin
        n_reset  = 1'b1;
        switches = 8'hA5;
        rd       = 1'b0;
        #1 n_reset = 1'b0;

        // Reset held with non-zero switches, then first acceptance after release.
        repeat (3) @(negedge clock);
        expect_out("reset_hold", 8'h00, 1'b0, 1'b0);
        n_reset = 1'b1;
        repeat (6) @(negedge clock);
        expect_out("release_edge6", 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        expect_out("release_edge7", 8'hA5, 1'b1, 1'b0);

        // Reset mid-debounce clears everything without a clock edge.
        switches = 8'h00;
        repeat (3) @(negedge clock);
        #1 n_reset = 1'b0;
        #1 expect_out("async_reset", 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        n_reset = 1'b1;
        repeat (10) @(negedge clock);
        expect_out("after_reset_idle", 8'h00, 1'b0, 1'b0);

        // Clean change lands exactly at edge 7.
        switches = 8'h3C;
        repeat (6) @(negedge clock);
        expect_out("clean_edge6", 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        expect_out("clean_edge7", 8'h3C, 1'b1, 1'b0);

        // Bounce 3C/3D at 2-cycle intervals, then hold 3D.
        pulse_rd();
        expect_out("bounce_clear", 8'h3C, 1'b0, 1'b0);
        switches = 8'h3D;
        repeat (2) @(negedge clock);
        switches = 8'h3C;
        repeat (2) @(negedge clock);
        switches = 8'h3D;
        repeat (6) @(negedge clock);
        expect_out("bounce_edge6", 8'h3C, 1'b0, 1'b0);
        @(negedge clock);
        expect_out("bounce_edge7", 8'h3D, 1'b1, 1'b0);

        // Two accepts without a read raise overrun; a read clears both flags.
        pulse_rd();
        switches = 8'h11;
        repeat (8) @(negedge clock);
        expect_out("ovr_first", 8'h11, 1'b1, 1'b0);
        switches = 8'h22;
        repeat (8) @(negedge clock);
        expect_out("ovr_second", 8'h22, 1'b1, 1'b1);
        pulse_rd();
        expect_out("ovr_read", 8'h22, 1'b0, 1'b0);

        // Read on the same edge as the accept of 44.
        switches = 8'h44;
        repeat (6) @(negedge clock);
        expect_out("simul_before", 8'h22, 1'b0, 1'b0);
        pulse_rd();
        expect_out("simul_accept", 8'h44, 1'b1, 1'b0);

        // One-cycle glitch away from and back to the published value.
        switches = 8'h45;
        @(negedge clock);
        switches = 8'h44;
        repeat (10) @(negedge clock);
        expect_out("glitch_same", 8'h44, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_input.md
Name: switch_input

Overview:
- Conditions the raw slide-switch vector before the CPU reads it as memory-mapped input data at the top data address (31 for WORD_W=8, OP_W=3).
- Synchronises the asynchronous switches into the clock domain, debounces the whole word, and holds a stable registered copy on Sdata.
- Flags new data with a sticky new-data bit and an overrun bit.
- Sits directly upstream of the CPU data-read mux, replacing direct use of the raw switches.

Parameters:
- WORD_W, 8: width of switch vector and data word.
- OP_W, 3: opcode width; the I/O address is derived from it.
- DB_CYCLES, 50000: number of consecutive identical synchronised samples required before acceptance. Must be >= 2.
- CNT_W, $clog2(DB_CYCLES): debounce counter width.

Ports:
- clock  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- switches  input  WORD_W  raw asynchronous switch levels.
- rd  input  1  one-cycle read strobe, asserted by the CPU when it reads the switch address.
- Sdata  output  WORD_W  debounced stable switch word.
- new_data  output  1  sticky: a value was accepted that has not yet been read.
- overrun  output  1  sticky: a value was accepted while new_data was already set.

Behaviour:
- Reset:
  - Asynchronous, active-low, single clock.
  - While n_reset=0: both sync flops, cand, cnt, Sdata, new_data and overrun are all 0.
  - Reset asserted mid-debounce discards the count.
- Sync stage: two flops, s1<=switches and s2<=s1. Only s2 is used downstream.
- Debounce, evaluated at each rising edge in priority order:
  - If s2 != cand: cand<=s2 and cnt<=0.
  - Else if cnt < DB_CYCLES-1: cnt<=cnt+1.
  - Else (cnt == DB_CYCLES-1, saturated) and cand != Sdata: Sdata<=cand. This is the accept event.
  - cnt saturates at DB_CYCLES-1 and never wraps.
- Latency: a switch change that stays stable appears on Sdata at rising edge DB_CYCLES+3, counting the first edge that samples it as edge 1. With DB_CYCLES=4 that is edge 7.
- Glitches: any change in s2 shorter than DB_CYCLES samples restarts cnt, and Sdata is unchanged.
- A bounce that returns to the current Sdata value produces no accept event and no flags.
- Flags:
  - On accept: new_data<=1. If new_data was already 1, overrun<=1 as well.
  - On rd with no accept in the same cycle: new_data<=0 and overrun<=0.
  - rd and accept in the same cycle: set wins. new_data=1, and overrun is unchanged by the read.
  - rd while new_data=0 has no effect.
- Reset release: if the switches are non-zero, the first acceptance after release sets new_data; this is expected.
- All outputs are registered. Sdata never changes except on an accept event.

Decomposition:
- Package cpu_pkg holds:
  - WORD_W and OP_W defaults.
  - SW_ADDR = 2**(WORD_W-OP_W)-1.
  - DISP_ADDR = 2**(WORD_W-OP_W)-2.
- The CPU top uses SW_ADDR both to generate rd and to select Sdata.
- One sub-module, sync2: a parameterised-width two-flop synchroniser with asynchronous active-low reset.
- Debounce counter and flags stay in switch_input.

Test Plan (DB_CYCLES=4):
1. Reset: switches=8'hA5 with n_reset held low, then assert n_reset low mid-run → Sdata=00, new_data=0, overrun=0 immediately, without waiting for a clock edge.
2. Clean change: after release, switches 00→3C and held → Sdata=3C and new_data=1 exactly at edge 7, with no change before it.
3. Bounce: switches toggle 3C→3D→3C→3D with 2-cycle intervals, then hold 3D → Sdata stays 3C until 3D has been stable for the full latency, then Sdata=3D with a single accept event.
4. Overrun: accept 11, no rd, then accept 22 → new_data=1 and overrun=1. Pulse rd → both flags 0, Sdata=22.
5. Simultaneous: rd asserted on the same edge as the accept of 44 → new_data=1, Sdata=44, and overrun keeps its prior value.
6. Glitch to same value: Sdata=44, switches pulse to 45 for 1 cycle → no accept, new_data unchanged, cnt restarts and then saturates.
